// File: rtl/song_sequencer.sv
// Song sequencer: walks a song ROM entry by entry, hands each note/duration
// pair to the note player and waits for it to finish before advancing.
module song_sequencer #(
    parameter int SONG_BITS = 2,
    parameter int NOTE_BITS = 5
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           play,
    input  logic [SONG_BITS-1:0]           song,
    input  logic                           new_song,
    output logic [SONG_BITS+NOTE_BITS-1:0] rom_addr,
    input  logic [11:0]                    rom_data,
    output logic [5:0]                     note_to_load,
    output logic [5:0]                     duration_to_load,
    output logic                           load_new_note,
    input  logic                           note_done,
    output logic                           song_done,
    output logic [NOTE_BITS-1:0]           note_index
);

    // state     | meaning
    // IDLE      | after reset, waiting for play
    // FETCH     | rom_addr presented, ROM read in flight
    // WAIT_ROM  | rom_data valid; leaving this state registers the load/done pulse
    // LOAD      | load_new_note (or song_done) is visible this cycle
    // SETTLE    | one-cycle mask for a stale note_done from the previous note
    // WAIT_NOTE | waiting for the note player to finish
    // DONE      | end of song; only new_song or reset leaves
    typedef enum logic [2:0] {
        IDLE, FETCH, WAIT_ROM, LOAD, SETTLE, WAIT_NOTE, DONE
    } state_t;

    state_t                 state, state_next;
    logic [SONG_BITS-1:0]   song_reg, song_reg_next;
    logic [NOTE_BITS-1:0]   index_next;
    logic [5:0]             note_next, duration_next;
    logic                   load_next, done_next;

    assign rom_addr = {song_reg, note_index};

    // Pulses are registered on the WAIT_ROM->LOAD edge so that they and the
    // note/duration registers become visible together in the LOAD cycle.
    always_comb begin
        state_next    = state;
        song_reg_next = song_reg;
        index_next    = note_index;
        note_next     = note_to_load;
        duration_next = duration_to_load;
        load_next     = 1'b0;
        done_next     = 1'b0;
        if (new_song) begin
            song_reg_next = song;
            index_next    = '0;
            state_next    = FETCH;
        end else begin
            case (state)
                IDLE:     if (play) state_next = FETCH;
                FETCH:    if (play) state_next = WAIT_ROM;
                WAIT_ROM: begin
                    if (play) begin
                        state_next = LOAD;
                        if (rom_data[5:0] == '0) begin
                            done_next = 1'b1;
                        end else begin
                            load_next     = 1'b1;
                            note_next     = rom_data[11:6];
                            duration_next = rom_data[5:0];
                        end
                    end
                end
                LOAD:     state_next = song_done ? DONE : SETTLE;
                SETTLE:   state_next = WAIT_NOTE;
                WAIT_NOTE: begin
                    if (note_done) begin
                        if (&note_index) begin
                            done_next  = 1'b1;
                            state_next = DONE;
                        end else begin
                            index_next = note_index + NOTE_BITS'(1);
                            state_next = FETCH;
                        end
                    end
                end
                DONE:     state_next = DONE;
                default:  state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            song_reg         <= '0;
            note_index       <= '0;
            note_to_load     <= '0;
            duration_to_load <= '0;
            load_new_note    <= 1'b0;
            song_done        <= 1'b0;
        end else begin
            state            <= state_next;
            song_reg         <= song_reg_next;
            note_index       <= index_next;
            note_to_load     <= note_next;
            duration_to_load <= duration_next;
            load_new_note    <= load_next;
            song_done        <= done_next;
        end
    end

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: a ROM with one cycle of read latency, a simple
// note-player responder, and per-scenario tasks checked against ROM contents.
module tb_song_sequencer;
    logic        clk = 1'b0;
    logic        reset, play, new_song, note_done;
    logic [1:0]  song;
    logic [6:0]  rom_addr;
    logic [11:0] rom_data;
    logic [5:0]  note_to_load, duration_to_load;
    logic        load_new_note, song_done;
    logic [4:0]  note_index;
    logic [11:0] rom [0:127];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= rom[rom_addr];

    song_sequencer #(.SONG_BITS(2), .NOTE_BITS(5)) dut (
        .clk(clk), .reset(reset), .play(play), .song(song), .new_song(new_song),
        .rom_addr(rom_addr), .rom_data(rom_data), .note_to_load(note_to_load),
        .duration_to_load(duration_to_load), .load_new_note(load_new_note),
        .note_done(note_done), .song_done(song_done), .note_index(note_index)
    );

    // The two pulses must never coincide.
    always @(negedge clk) begin
        if (load_new_note || song_done) begin
            n_cmp++;
            if (load_new_note && song_done) begin
                n_bad++;
                $display("FAIL overlap: load_new_note=1 and song_done=1 at %0t, required exclusive", $time);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Fills a song with random entries; entry end_at (if < 32) gets duration 0.
    task automatic fill_song(input int s, input int end_at);
        logic [6:0] a;
        for (int i = 0; i < 32; i++) begin
            a = {2'(s), 5'(i)};
            rom[a] = {6'($urandom_range(0, 63)), 6'($urandom_range(1, 63))};
            if (i == end_at) rom[a][5:0] = 6'd0;
        end
    endtask

    // Plays a song from entry 0 with random play drops and note-player delays.
    // Expected: entries loaded in order up to the first zero duration (or all 32),
    // then exactly one song_done.
    task automatic run_song(input int s, input int end_at);
        int         exp_n;
        int         got, dones, cnt, wait_cnt;
        bit         clear_pending;
        logic [6:0] a;
        exp_n = (end_at < 32) ? end_at : 32;
        got = 0; dones = 0; cnt = 0; wait_cnt = 0; clear_pending = 0;
        song = 2'(s); new_song = 1; play = 1; note_done = 0;
        step();
        new_song = 0;
        while (dones == 0 && cnt < 3000) begin
            play = ($urandom_range(0, 3) != 0);
            if (load_new_note) begin
                n_cmp++;
                a = {2'(s), 5'(got)};
                if (got >= exp_n || {note_to_load, duration_to_load} !== rom[a] || note_index !== 5'(got)) begin
                    n_bad++;
                    $display("FAIL run_song%0d load %0d: got note=%0d dur=%0d idx=%0d, required note=%0d dur=%0d idx=%0d (expected %0d loads)",
                             s, got, note_to_load, duration_to_load, note_index, rom[a][11:6], rom[a][5:0], got, exp_n);
                end
                got++;
                clear_pending = 1;
                wait_cnt = $urandom_range(1, 6);
            end else if (clear_pending) begin
                note_done = 0;
                clear_pending = 0;
            end else if (wait_cnt > 0) begin
                wait_cnt--;
                if (wait_cnt == 0) note_done = 1;
            end
            if (song_done) dones++;
            step();
            cnt++;
        end
        n_cmp++;
        if (dones != 1 || got != exp_n) begin
            n_bad++;
            $display("FAIL run_song%0d end: got %0d loads, %0d song_done in %0d cycles, required %0d loads, 1 song_done",
                     s, got, dones, cnt, exp_n);
        end
    endtask

    task automatic test_reset();
        reset = 1; play = 0; new_song = 0; note_done = 0; song = 0;
        step(); step();
        n_cmp++;
        if ({note_to_load, duration_to_load, load_new_note, song_done} !== 14'd0) begin
            n_bad++;
            $display("FAIL reset outputs: got note=%0d dur=%0d load=%0b done=%0b, required all 0",
                     note_to_load, duration_to_load, load_new_note, song_done);
        end
        n_cmp++;
        if (rom_addr !== 7'd0 || note_index !== 5'd0) begin
            n_bad++;
            $display("FAIL reset addr: got rom_addr=%h idx=%0d, required 00/0", rom_addr, note_index);
        end
        reset = 0;
        step(); step();
        n_cmp++;
        if (load_new_note !== 1'b0 || rom_addr !== 7'd0) begin
            n_bad++;
            $display("FAIL idle hold: got load=%0b rom_addr=%h, required 0/00", load_new_note, rom_addr);
        end
    endtask

    task automatic test_first_load();
        rom[7'h20] = {6'd20, 6'd12};
        rom[7'h21] = {6'd33, 6'd7};
        song = 1; new_song = 1; play = 1; note_done = 0;
        step();                       // FETCH
        new_song = 0;
        n_cmp++;
        if (rom_addr !== 7'h20 || load_new_note !== 1'b0) begin
            n_bad++;
            $display("FAIL first fetch: got rom_addr=%h load=%0b, required 20/0", rom_addr, load_new_note);
        end
        step();                       // WAIT_ROM
        note_done = 1;                // stale level from a previous note
        n_cmp++;
        if (load_new_note !== 1'b0) begin
            n_bad++;
            $display("FAIL first load early: got load=%0b, required 0", load_new_note);
        end
        step();                       // LOAD
        n_cmp++;
        if (load_new_note !== 1'b1 || note_to_load !== 6'd20 || duration_to_load !== 6'd12) begin
            n_bad++;
            $display("FAIL first load: got load=%0b note=%0d dur=%0d, required 1/20/12",
                     load_new_note, note_to_load, duration_to_load);
        end
        step();                       // SETTLE
        n_cmp++;
        if (load_new_note !== 1'b0 || note_to_load !== 6'd20 || note_index !== 5'd0) begin
            n_bad++;
            $display("FAIL pulse width/hold: got load=%0b note=%0d idx=%0d, required 0/20/0",
                     load_new_note, note_to_load, note_index);
        end
        step();                       // WAIT_NOTE; stale note_done seen only in SETTLE
        note_done = 0;
        n_cmp++;
        if (note_index !== 5'd0) begin
            n_bad++;
            $display("FAIL stale note_done: got idx=%0d, required 0", note_index);
        end
        step(); step();
        n_cmp++;
        if (note_index !== 5'd0 || load_new_note !== 1'b0) begin
            n_bad++;
            $display("FAIL wait_note hold: got idx=%0d load=%0b, required 0/0", note_index, load_new_note);
        end
        note_done = 1;
        step();                       // FETCH of entry 1
        note_done = 0;
        n_cmp++;
        if (note_index !== 5'd1 || rom_addr !== 7'h21 || load_new_note !== 1'b0) begin
            n_bad++;
            $display("FAIL advance: got idx=%0d rom_addr=%h load=%0b, required 1/21/0",
                     note_index, rom_addr, load_new_note);
        end
        step();
        n_cmp++;
        if (load_new_note !== 1'b0) begin
            n_bad++;
            $display("FAIL second load early: got load=%0b, required 0", load_new_note);
        end
        step();
        n_cmp++;
        if (load_new_note !== 1'b1 || note_to_load !== 6'd33 || duration_to_load !== 6'd7) begin
            n_bad++;
            $display("FAIL second load: got load=%0b note=%0d dur=%0d, required 1/33/7",
                     load_new_note, note_to_load, duration_to_load);
        end
    endtask

    task automatic test_play_pause();
        int loads;
        fill_song(0, 32);
        song = 0; new_song = 1; play = 1; note_done = 0;
        step();                       // FETCH
        new_song = 0;
        step();                       // WAIT_ROM
        play = 0;
        loads = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (load_new_note) loads++;
        end
        n_cmp++;
        if (loads != 0) begin
            n_bad++;
            $display("FAIL pause in wait_rom: got %0d loads, required 0", loads);
        end
        play = 1;
        step();
        n_cmp++;
        if (load_new_note !== 1'b1 || {note_to_load, duration_to_load} !== rom[7'h00]) begin
            n_bad++;
            $display("FAIL resume load: got load=%0b data=%h, required 1/%h",
                     load_new_note, {note_to_load, duration_to_load}, rom[7'h00]);
        end
        play = 0;
        step(); step(); step(); step();
        n_cmp++;
        if (note_index !== 5'd0) begin
            n_bad++;
            $display("FAIL paused wait_note: got idx=%0d, required 0", note_index);
        end
        note_done = 1;
        step();
        note_done = 0;
        n_cmp++;
        if (note_index !== 5'd1) begin
            n_bad++;
            $display("FAIL note_done while paused: got idx=%0d, required 1", note_index);
        end
        loads = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (load_new_note) loads++;
        end
        n_cmp++;
        if (loads != 0) begin
            n_bad++;
            $display("FAIL pause in fetch: got %0d loads, required 0", loads);
        end
        play = 1;
        step();
        n_cmp++;
        if (load_new_note !== 1'b0) begin
            n_bad++;
            $display("FAIL resume fetch early: got load=%0b, required 0", load_new_note);
        end
        step();
        n_cmp++;
        if (load_new_note !== 1'b1 || {note_to_load, duration_to_load} !== rom[7'h01] || note_index !== 5'd1) begin
            n_bad++;
            $display("FAIL resume fetch load: got load=%0b data=%h idx=%0d, required 1/%h/1",
                     load_new_note, {note_to_load, duration_to_load}, note_index, rom[7'h01]);
        end
    endtask

    task automatic test_end_marker();
        int loads, dones;
        fill_song(1, 5);
        run_song(1, 5);
        play = 1; note_done = 1;
        loads = 0; dones = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (load_new_note) loads++;
            if (song_done) dones++;
        end
        n_cmp++;
        if (loads != 0 || dones != 0) begin
            n_bad++;
            $display("FAIL done hold: got %0d loads %0d song_done, required 0/0", loads, dones);
        end
        n_cmp++;
        if ({note_to_load, duration_to_load} !== rom[7'h24]) begin
            n_bad++;
            $display("FAIL end marker hold: got data=%h, required %h", {note_to_load, duration_to_load}, rom[7'h24]);
        end
        note_done = 0;
    endtask

    task automatic test_full_song();
        int loads, dones;
        fill_song(3, 32);
        run_song(3, 32);
        n_cmp++;
        if (note_index !== 5'd31 || rom_addr !== 7'h7f) begin
            n_bad++;
            $display("FAIL full song index: got idx=%0d rom_addr=%h, required 31/7f", note_index, rom_addr);
        end
        play = 1; note_done = 1;
        loads = 0; dones = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (load_new_note) loads++;
            if (song_done) dones++;
        end
        n_cmp++;
        if (loads != 0 || dones != 0) begin
            n_bad++;
            $display("FAIL full song wrap: got %0d loads %0d song_done, required 0/0", loads, dones);
        end
        note_done = 0;
    endtask

    task automatic test_back_to_back();
        int t;
        fill_song(1, 32);
        fill_song(2, 32);
        song = 1; new_song = 1; play = 1; note_done = 0;
        step();
        new_song = 0;
        for (int k = 0; k < 8; k++) begin
            t = 0;
            while (!load_new_note && t < 20) begin
                step();
                t++;
            end
            n_cmp++;
            if (!load_new_note) begin
                n_bad++;
                $display("FAIL load timeout: got no load for entry %0d in %0d cycles, required a load", k, t);
            end
            step(); step();           // SETTLE, WAIT_NOTE
            if (k < 7) begin
                note_done = 1;
                step();
                note_done = 0;
            end
        end
        n_cmp++;
        if (note_index !== 5'd7) begin
            n_bad++;
            $display("FAIL reach index 7: got idx=%0d, required 7", note_index);
        end
        note_done = 1; new_song = 1; song = 2;
        step();
        note_done = 0; new_song = 0;
        n_cmp++;
        if (note_index !== 5'd0 || rom_addr !== 7'h40 || load_new_note !== 1'b0) begin
            n_bad++;
            $display("FAIL new_song priority: got idx=%0d rom_addr=%h load=%0b, required 0/40/0",
                     note_index, rom_addr, load_new_note);
        end
        step(); step();
        n_cmp++;
        if (load_new_note !== 1'b1 || {note_to_load, duration_to_load} !== rom[7'h40] || note_index !== 5'd0) begin
            n_bad++;
            $display("FAIL new_song load: got load=%0b data=%h idx=%0d, required 1/%h/0",
                     load_new_note, {note_to_load, duration_to_load}, note_index, rom[7'h40]);
        end
        step(); step();               // WAIT_NOTE
        reset = 1;
        step();
        n_cmp++;
        if ({note_to_load, duration_to_load, load_new_note, song_done} !== 14'd0 ||
            rom_addr !== 7'd0 || note_index !== 5'd0) begin
            n_bad++;
            $display("FAIL mid reset: got note=%0d dur=%0d load=%0b done=%0b rom_addr=%h idx=%0d, required all 0",
                     note_to_load, duration_to_load, load_new_note, song_done, rom_addr, note_index);
        end
        reset = 0; play = 1;
        step(); step();
        n_cmp++;
        if (load_new_note !== 1'b0) begin
            n_bad++;
            $display("FAIL restart from idle early: got load=%0b, required 0", load_new_note);
        end
        step();
        n_cmp++;
        if (load_new_note !== 1'b1 || {note_to_load, duration_to_load} !== rom[7'h00]) begin
            n_bad++;
            $display("FAIL restart from idle load: got load=%0b data=%h, required 1/%h",
                     load_new_note, {note_to_load, duration_to_load}, rom[7'h00]);
        end
    endtask

    initial begin
        reset = 1; play = 0; new_song = 0; note_done = 0; song = 0;
        for (int i = 0; i < 128; i++)
            rom[i] = {6'($urandom_range(0, 63)), 6'($urandom_range(1, 63))};
        test_reset();
        test_first_load();
        test_play_pause();
        test_end_marker();
        test_full_song();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Controller that drives the note player. It steps through a song stored in an external song ROM and issues one note/duration pair per load pulse.
- Waits for the note player's done indication before advancing to the next entry, and flags the end of the song.
- Sits between the top-level user controls (play, song select) and the note player.
- Sequential: 7-state FSM, note index counter, latched song select, ROM-latency handling.

Parameters:
- SONG_BITS, 2, width of song select; 2^SONG_BITS songs.
- NOTE_BITS, 5, width of note index; 2^NOTE_BITS entries per song.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- play  input  1  level; high = advance the song, low = pause sequencing
- song  input  SONG_BITS  song to start; sampled only on new_song
- new_song  input  1  one-cycle pulse; restart at entry 0 of `song`
- rom_addr  output  SONG_BITS+NOTE_BITS  {song_reg, note_index}; always driven
- rom_data  input  12  {note[11:6], duration[5:0]}; valid 1 cycle after rom_addr changes
- note_to_load  output  6  registered note code for the note player
- duration_to_load  output  6  registered duration in beats for the note player
- load_new_note  output  1  one-cycle pulse; note/duration valid in the same cycle
- note_done  input  1  level from the note player's done_with_note
- song_done  output  1  one-cycle pulse at end of song
- note_index  output  NOTE_BITS  current entry index, for display

Behaviour:
- Reset (synchronous, highest priority, also mid-operation):
  - state=IDLE, song_reg=0, note_index=0.
  - note_to_load=0, duration_to_load=0, load_new_note=0, song_done=0.
- States: IDLE, FETCH, WAIT_ROM, LOAD, SETTLE, WAIT_NOTE, DONE.
- IDLE: play=1 -> FETCH; otherwise hold.
- FETCH: rom_addr is already presented. play=1 -> WAIT_ROM; play=0 -> hold.
- WAIT_ROM: rom_data becomes valid here. play=1 -> LOAD; play=0 -> hold. rom_addr is stable, so the data stays valid while held.
- LOAD:
  - If rom_data[5:0]==0: end-of-song marker. No load pulse; song_done=1 for one cycle; -> DONE.
  - Otherwise: register note_to_load=rom_data[11:6] and duration_to_load=rom_data[5:0]; load_new_note=1 for exactly this cycle; -> SETTLE.
- SETTLE: one cycle, always -> WAIT_NOTE. This masks a stale-high note_done left over from the previous note.
- WAIT_NOTE: waits for note_done=1. This state is not gated by play; the note player pauses itself via play_enable.
  - On note_done with note_index==2^NOTE_BITS-1: song_done pulse; -> DONE. note_index does not wrap into a new load.
  - On note_done otherwise: note_index+1; -> FETCH.
- DONE: hold. play is ignored. Only new_song or reset leaves this state.
- Latency: play sampled high in IDLE at edge N gives load_new_note=1 during cycle N+3 (FETCH, WAIT_ROM, LOAD). note_done sampled in WAIT_NOTE at edge M gives the next load_new_note during cycle M+3 if play stays high.
- new_song (any state except reset):
  - song_reg<=song, note_index<=0, song_done forced 0, next state FETCH.
  - Takes priority over a simultaneous note_done; the index is not incremented.
  - A note in progress is superseded by the next load_new_note. The note player treats each load as an override.
- load_new_note and song_done are never high in the same cycle. Each pulse is exactly one cycle.
- note_to_load and duration_to_load hold their values between loads.

Test Plan (SONG_BITS=2, NOTE_BITS=5):
- Reset, new_song with song=1, play=1, ROM[7'h20]={6'd20,6'd12} -> rom_addr=7'h20; load_new_note high for exactly 1 cycle, 3 cycles after FETCH entry, with note_to_load=20 and duration_to_load=12.
- note_done held high across the load (stale) -> no advance during SETTLE. A fresh note_done in WAIT_NOTE -> note_index=1, rom_addr=7'h21, next load 3 cycles later.
- Song 1 entry 5 has duration 0 -> no load pulse; song_done=1 for 1 cycle; state stays DONE with play=1 for 100 cycles and no further loads.
- All 32 entries nonzero; note_done after index 31 -> song_done pulse, no load from 7'h20; DONE until new_song.
- play=0 during WAIT_ROM for 10 cycles -> no load_new_note until play=1, then the load fires 1 cycle later with the correct data. play=0 in WAIT_NOTE -> remains there; note_done still advances.
- new_song (song=2) in the same cycle as note_done at index 7 -> note_index=0, rom_addr=7'h40, no increment. Separately, reset asserted mid-WAIT_NOTE -> all outputs 0 next cycle, state IDLE.
